// File: rtl/imem_encoder_pkg.sv
// imem_encoder_pkg: LEGv8 opcodes, field positions and shared types for the instruction encoder.
package imem_encoder_pkg;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam int OPC_LSB    = 21;
    localparam int CB_OPC_LSB = 24;
    localparam int RM_LSB     = 16;
    localparam int D_IMM_LSB  = 12;
    localparam int CB_IMM_LSB = 5;
    localparam int RN_LSB     = 5;
    localparam int RD_LSB     = 0;
    localparam int D_IMM_W    = 9;
    localparam int CB_IMM_W   = 19;
    typedef enum logic [2:0] {
        OP_LDUR, OP_STUR, OP_CBZ, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ILLEGAL
    } op_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    // Fits when every bit from the field's sign bit upward is identical.
    function automatic logic fits_signed(input logic [63:0] imm, input int w);
        logic [63:0] t;
        t = $signed(imm) >>> (w - 1);
        return (t == '0) || (t == '1);
    endfunction
endpackage

// File: rtl/imem_encoder_pack.sv
// instr_pack: combinational LEGv8 field packer with immediate range check.
module instr_pack
    import imem_encoder_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [63:0] imm,
    output logic [31:0] instr,
    output logic        ok
);
    logic [31:0] regs;
    logic [10:0] r_opc;
    always_comb begin
        regs  = (32'(rn) << RN_LSB) | (32'(rd) << RD_LSB);
        r_opc = op == OP_SUB ? OPC_SUB : op == OP_AND ? OPC_AND : op == OP_ORR ? OPC_ORR : OPC_ADD;
        instr = (32'(r_opc) << OPC_LSB) | (32'(rm) << RM_LSB) | regs;
        ok    = op != OP_ILLEGAL;
        if (op == OP_LDUR || op == OP_STUR) begin
            instr = (32'(op == OP_LDUR ? OPC_LDUR : OPC_STUR) << OPC_LSB)
                  | (32'(imm[D_IMM_W-1:0]) << D_IMM_LSB) | regs;
            ok    = fits_signed(imm, D_IMM_W);
        end else if (op == OP_CBZ) begin
            instr = (32'(OPC_CBZ) << CB_OPC_LSB)
                  | (32'(imm[CB_IMM_W-1:0]) << CB_IMM_LSB) | (32'(rd) << RD_LSB);
            ok    = fits_signed(imm, CB_IMM_W);
        end
    end
endmodule

// File: rtl/imem_encoder.sv
// imem_encoder: streams packed LEGv8 words with sequential addresses to the instruction-memory loader.
module imem_encoder
    import imem_encoder_pkg::*;
#(
    parameter int AW  = 6,
    parameter int ECW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     in_op,
    input  logic [4:0]     in_rd,
    input  logic [4:0]     in_rn,
    input  logic [4:0]     in_rm,
    input  logic [63:0]    in_imm,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [AW-1:0]  out_addr,
    output logic [31:0]    out_instr,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [ECW-1:0] err_count
);
    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d, out_addr_q, out_addr_d;
    logic [31:0]    out_instr_q, out_instr_d, packed_instr;
    logic [ECW-1:0] err_cnt_q, err_cnt_d;
    logic           out_valid_q, out_valid_d, err_q, err_d;
    logic           ok, accept, produce, launch;

    instr_pack u_pack (
        .op(in_op), .rd(in_rd), .rn(in_rn), .rm(in_rm), .imm(in_imm),
        .instr(packed_instr), .ok(ok)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;

    // A rejected last bundle has no word in flight, so it skips DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN:          if (accept && (in_last || (produce && addr_q == '1)))
                                state_d = ok ? S_DRAIN : S_DONE;
            default:        if (!out_valid_q || out_ready) state_d = S_DONE;
        endcase
    end

    always_comb begin
        in_ready = state_q == S_RUN && (!out_valid_q || out_ready);
        busy     = state_q == S_RUN || state_q == S_DRAIN;
        done     = state_q == S_DONE;
        launch   = start && (state_q == S_IDLE || state_q == S_DONE);
        accept   = in_valid && in_ready;
        produce  = accept && ok;
    end

    always_comb begin
        out_valid_d = produce || (out_valid_q && !out_ready);
        out_addr_d  = produce ? addr_q : out_addr_q;
        out_instr_d = produce ? packed_instr : out_instr_q;
        addr_d      = launch ? '0 : produce ? addr_q + 1'b1 : addr_q;
        err_d       = accept && !ok;
        err_cnt_d   = launch ? '0 : (err_d && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_instr_q <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_instr_q <= out_instr_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_instr = out_instr_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_imem_encoder.sv
// tb_imem_encoder: directed vector table plus hand-written session sequences for imem_encoder.
module tb_imem_encoder;
    localparam int AW  = 2;
    localparam int ECW = 8;
    localparam int NV  = 17;

    logic           clk = 1'b0;
    logic           reset, start, in_valid, in_last, out_ready;
    logic           in_ready, out_valid, busy, done, err;
    logic [2:0]     in_op;
    logic [4:0]     in_rd, in_rn, in_rm;
    logic [63:0]    in_imm;
    logic [AW-1:0]  out_addr;
    logic [31:0]    out_instr;
    logic [ECW-1:0] err_count;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd, rn, rm;
        logic [63:0] imm;
        logic        ok;
        logic [31:0] instr;
    } vec_t;
    vec_t vt [NV];

    imem_encoder #(.AW(AW), .ECW(ECW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_instr(out_instr), .busy(busy), .done(done), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [63:0] imm, input logic last);
        in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_last = last;
        in_valid = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after the bundle is taken.
    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [63:0] imm, input logic last);
        int n = 0;
        drive(op, rd, rn, rm, imm, last);
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("send_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        vt[0]  = '{3'd0, 5'd1,  5'd2,  5'd0,  64'd8,                    1'b1, 32'hF8408041};
        vt[1]  = '{3'd1, 5'd3,  5'd4,  5'd0,  -64'sd8,                  1'b1, 32'hF81F8083};
        vt[2]  = '{3'd2, 5'd5,  5'd0,  5'd0,  -64'sd2,                  1'b1, 32'hB4FFFFC5};
        vt[3]  = '{3'd3, 5'd9,  5'd10, 5'd11, 64'd0,                    1'b1, 32'h8B0B0149};
        vt[4]  = '{3'd4, 5'd1,  5'd2,  5'd3,  64'd0,                    1'b1, 32'hCB030041};
        vt[5]  = '{3'd5, 5'd31, 5'd31, 5'd31, 64'd0,                    1'b1, 32'h8A1F03FF};
        vt[6]  = '{3'd6, 5'd0,  5'd1,  5'd2,  64'd0,                    1'b1, 32'hAA020020};
        vt[7]  = '{3'd0, 5'd0,  5'd0,  5'd0,  64'd255,                  1'b1, 32'hF84FF000};
        vt[8]  = '{3'd1, 5'd0,  5'd0,  5'd0,  -64'sd256,                1'b1, 32'hF8100000};
        vt[9]  = '{3'd0, 5'd0,  5'd0,  5'd0,  64'd256,                  1'b0, 32'h0};
        vt[10] = '{3'd1, 5'd0,  5'd0,  5'd0,  -64'sd257,                1'b0, 32'h0};
        vt[11] = '{3'd2, 5'd0,  5'd0,  5'd0,  64'd262143,               1'b1, 32'hB47FFFE0};
        vt[12] = '{3'd2, 5'd7,  5'd0,  5'd0,  -64'sd262144,             1'b1, 32'hB4800007};
        vt[13] = '{3'd2, 5'd0,  5'd0,  5'd0,  64'd262144,               1'b0, 32'h0};
        vt[14] = '{3'd7, 5'd1,  5'd2,  5'd3,  64'd0,                    1'b0, 32'h0};
        vt[15] = '{3'd3, 5'd9,  5'd10, 5'd11, 64'h8000_0000_0000_0000,  1'b1, 32'h8B0B0149};
        vt[16] = '{3'd0, 5'd1,  5'd2,  5'd0,  64'h0000_0001_0000_0008,  1'b0, 32'h0};

        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_err_count", err_count, 0);
        in_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            do_start();
            send(vt[i].op, vt[i].rd, vt[i].rn, vt[i].rm, vt[i].imm, 1'b1);
            if (vt[i].ok) begin
                check($sformatf("vec%0d_valid", i), out_valid, 1);
                check($sformatf("vec%0d_instr", i), out_instr, vt[i].instr);
                check($sformatf("vec%0d_addr", i), out_addr, 0);
                check($sformatf("vec%0d_err", i), err, 0);
                @(negedge clk);
                check($sformatf("vec%0d_done", i), done, 1);
            end else begin
                check($sformatf("vec%0d_err", i), err, 1);
                check($sformatf("vec%0d_valid", i), out_valid, 0);
                check($sformatf("vec%0d_done", i), done, 1);
                check($sformatf("vec%0d_err_count", i), err_count, 1);
            end
        end

        // Three-word session, with a start pulse while busy that must be ignored.
        do_start();
        send(3'd0, 5'd1, 5'd2, 5'd0, 64'd8, 1'b0);
        check("seqA_w0_instr", out_instr, 32'hF8408041);
        check("seqA_w0_addr", out_addr, 0);
        do_start();
        check("seqA_busy_start", busy, 1);
        check("seqA_idle_out", out_valid, 0);
        send(3'd1, 5'd3, 5'd4, 5'd0, -64'sd8, 1'b0);
        check("seqA_w1_instr", out_instr, 32'hF81F8083);
        check("seqA_w1_addr", out_addr, 1);
        send(3'd2, 5'd5, 5'd0, 5'd0, -64'sd2, 1'b1);
        check("seqA_w2_instr", out_instr, 32'hB4FFFFC5);
        check("seqA_w2_addr", out_addr, 2);
        check("seqA_drain_busy", busy, 1);
        @(negedge clk);
        check("seqA_done", done, 1);
        check("seqA_not_busy", busy, 0);

        // Output stall, then two rejects and a word at the next address.
        do_start();
        out_ready = 1'b0;
        send(3'd3, 5'd9, 5'd10, 5'd11, 64'd0, 1'b0);
        drive(3'd0, 5'd0, 5'd0, 5'd0, 64'd256, 1'b0);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("seqB_stall%0d_valid", k), out_valid, 1);
            check($sformatf("seqB_stall%0d_instr", k), out_instr, 32'h8B0B0149);
            check($sformatf("seqB_stall%0d_addr", k), out_addr, 0);
            check($sformatf("seqB_stall%0d_in_ready", k), in_ready, 0);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("seqB_ready_rise", in_ready, 1);
        @(negedge clk);
        check("seqB_rej1_err", err, 1);
        check("seqB_rej1_valid", out_valid, 0);
        check("seqB_rej1_count", err_count, 1);
        drive(3'd7, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
        @(negedge clk);
        check("seqB_rej2_err", err, 1);
        check("seqB_rej2_count", err_count, 2);
        send(3'd6, 5'd0, 5'd1, 5'd2, 64'd0, 1'b1);
        check("seqB_orr_instr", out_instr, 32'hAA020020);
        check("seqB_orr_addr", out_addr, 1);
        check("seqB_err_pulse", err, 0);
        check("seqB_count_hold", err_count, 2);
        @(negedge clk);
        check("seqB_done", done, 1);

        // Address space exhausted after 2^AW words without in_last.
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(3'd3, 5'(i), 5'd10, 5'd11, 64'd0, 1'b0);
            check($sformatf("seqC_w%0d_addr", i), out_addr, i);
            check($sformatf("seqC_w%0d_instr", i), out_instr, 32'h8B0B0140 | i);
        end
        drive(3'd3, 5'd4, 5'd10, 5'd11, 64'd0, 1'b0);
        #1;
        check("seqC_drain_busy", busy, 1);
        check("seqC_drain_in_ready", in_ready, 0);
        @(negedge clk);
        check("seqC_done", done, 1);
        check("seqC_done_in_ready", in_ready, 0);
        check("seqC_no_word", out_valid, 0);
        check("seqC_addr_hold", out_addr, 3);
        in_valid = 1'b0;

        // Error counter saturation.
        do_start();
        for (int i = 0; i < 300; i++) send(3'd7, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
        check("seqD_saturated", err_count, 8'hFF);
        send(3'd3, 5'd9, 5'd10, 5'd11, 64'd0, 1'b1);
        check("seqD_addr", out_addr, 0);
        check("seqD_count_hold", err_count, 8'hFF);
        @(negedge clk);
        check("seqD_done", done, 1);

        // Asynchronous reset with a word pending, then a fresh session.
        do_start();
        out_ready = 1'b0;
        send(3'd7, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
        send(3'd0, 5'd1, 5'd2, 5'd0, 64'd8, 1'b0);
        check("seqE_pending", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("seqE_rst_valid", out_valid, 0);
        check("seqE_rst_busy", busy, 0);
        check("seqE_rst_done", done, 0);
        check("seqE_rst_instr", out_instr, 0);
        check("seqE_rst_addr", out_addr, 0);
        check("seqE_rst_count", err_count, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("seqE_idle_busy", busy, 0);
        check("seqE_idle_done", done, 0);
        do_start();
        send(3'd1, 5'd3, 5'd4, 5'd0, -64'sd8, 1'b1);
        check("seqE_new_addr", out_addr, 0);
        check("seqE_new_instr", out_instr, 32'hF81F8083);
        check("seqE_new_count", err_count, 0);
        @(negedge clk);
        check("seqE_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
